// File: rtl/dual_port_block_ram.sv
// Dual-port block RAM: port A read/write with byte enables, port B read-only,
// 1- or 2-cycle read latency, selectable port-A read-during-write, and a sequential clear engine.
module dual_port_block_ram #(
  parameter int    ADDR_WIDTH     = 18,
  parameter int    DATA_WIDTH     = 8,
  parameter int    DEPTH          = 204800,
  parameter int    READ_LATENCY   = 1,
  parameter int    RDW_MODE       = 0,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string INIT_MEM_FILE  = ""
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_en,
  input  logic [DATA_WIDTH/8-1:0] a_we,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_din,
  output logic [DATA_WIDTH-1:0]   a_dout,
  output logic                    a_valid,
  input  logic                    b_en,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  output logic [DATA_WIDTH-1:0]   b_dout,
  output logic                    b_valid,
  input  logic                    clear_req,
  output logic                    busy
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(DEPTH - 1);

  if (DATA_WIDTH < 8 || DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH < 2 || MEM_AW > ADDR_WIDTH) begin : g_bad_depth
    $error("DEPTH must be at least 2 and fit in ADDR_WIDTH address bits");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if (INIT_MEM_FILE != "" && CLEAR_ON_RESET != 0) begin : g_init_wiped
    $warning("INIT_MEM_FILE contents are zeroed by the clear sweep after reset");
  end

  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  state_t                  state_q;
  logic                    busy_q;
  logic [ADDR_WIDTH-1:0]   clr_addr_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    a_acc, b_acc;
  logic                    a_in_range, b_in_range;
  logic [MEM_AW-1:0]       a_idx, b_idx, clr_idx;
  logic [DATA_WIDTH-1:0]   a_old, a_merged;
  logic [DATA_WIDTH-1:0]   a_rdata_d, b_rdata_d;
  logic [DATA_WIDTH-1:0]   a_s1_data_q, b_s1_data_q;
  logic                    a_s1_valid_q, b_s1_valid_q;

  assign a_idx   = a_addr[MEM_AW-1:0];
  assign b_idx   = b_addr[MEM_AW-1:0];
  assign clr_idx = clr_addr_q[MEM_AW-1:0];

  // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
  always_comb begin
    a_acc      = a_en & ~busy_q;
    b_acc      = b_en & ~busy_q;
    a_in_range = {1'b0, a_addr} < DEPTH_W;
    b_in_range = {1'b0, b_addr} < DEPTH_W;
    a_old      = a_in_range ? mem[a_idx] : '0;
    a_merged   = a_old;
    for (int i = 0; i < NB; i++) begin
      if (a_we[i]) a_merged[8*i +: 8] = a_din[8*i +: 8];
    end
    a_rdata_d  = (RDW_MODE != 0 && a_in_range) ? a_merged : a_old;
    b_rdata_d  = b_in_range ? mem[b_idx] : '0;
  end

  // NOTE: the array itself has no reset so it maps onto block RAM; zeroing is done by the clear sweep.
  always_ff @(posedge clk) begin
    if (busy_q) begin
      mem[clr_idx] <= '0;
    end else if (a_en && a_in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (a_we[i]) mem[a_idx][8*i +: 8] <= a_din[8*i +: 8];
      end
    end
  end

  // Clear engine: one word per cycle, busy registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RESET_STATE;
      busy_q     <= (CLEAR_ON_RESET != 0);
      clr_addr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clear_req) begin
            state_q    <= S_CLEAR;
            busy_q     <= 1'b1;
            clr_addr_q <= '0;
          end
        end
        S_CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == CLR_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_s1_data_q  <= '0;
      a_s1_valid_q <= 1'b0;
      b_s1_data_q  <= '0;
      b_s1_valid_q <= 1'b0;
    end else begin
      a_s1_valid_q <= a_acc;
      b_s1_valid_q <= b_acc;
      if (a_acc) a_s1_data_q <= a_rdata_d;
      if (b_acc) b_s1_data_q <= b_rdata_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] a_s2_data_q, b_s2_data_q;
    logic                  a_s2_valid_q, b_s2_valid_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        a_s2_data_q  <= '0;
        a_s2_valid_q <= 1'b0;
        b_s2_data_q  <= '0;
        b_s2_valid_q <= 1'b0;
      end else begin
        a_s2_valid_q <= a_s1_valid_q;
        b_s2_valid_q <= b_s1_valid_q;
        if (a_s1_valid_q) a_s2_data_q <= a_s1_data_q;
        if (b_s1_valid_q) b_s2_data_q <= b_s1_data_q;
      end
    end

    assign a_dout  = a_s2_data_q;
    assign a_valid = a_s2_valid_q;
    assign b_dout  = b_s2_data_q;
    assign b_valid = b_s2_valid_q;
  end else begin : g_lat1
    assign a_dout  = a_s1_data_q;
    assign a_valid = a_s1_valid_q;
    assign b_dout  = b_s1_data_q;
    assign b_valid = b_s1_valid_q;
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_dual_port_block_ram.sv
// Directed bench for dual_port_block_ram: three instances sharing stimulus
// (0: latency 1 read-first, 1: latency 1 write-first, 2: latency 2 read-first), DEPTH 16, 32-bit words.
module tb_dual_port_block_ram;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 16;

  logic          clk;
  logic          reset;
  logic          a_en;
  logic [3:0]    a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_din;
  logic          b_en;
  logic [AW-1:0] b_addr;
  logic          clear_req;

  logic [DW-1:0] a_dout [3];
  logic          a_valid [3];
  logic [DW-1:0] b_dout [3];
  logic          b_valid [3];
  logic          busy [3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dual_port_block_ram #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .DEPTH         (DEPTH),
      .READ_LATENCY  ((g == 2) ? 2 : 1),
      .RDW_MODE      ((g == 1) ? 1 : 0),
      .CLEAR_ON_RESET(1),
      .INIT_MEM_FILE ("")
    ) u_dut (
      .clk      (clk),
      .reset    (reset),
      .a_en     (a_en),
      .a_we     (a_we),
      .a_addr   (a_addr),
      .a_din    (a_din),
      .a_dout   (a_dout[g]),
      .a_valid  (a_valid[g]),
      .b_en     (b_en),
      .b_addr   (b_addr),
      .b_dout   (b_dout[g]),
      .b_valid  (b_valid[g]),
      .clear_req(clear_req),
      .busy     (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_en = 1'b0; a_we = 4'h0; b_en = 1'b0; clear_req = 1'b0;
  endtask

  task automatic a_write(input int addr, input logic [DW-1:0] data, input logic [3:0] we);
    a_en = 1'b1; a_we = we; a_addr = AW'(addr); a_din = data;
    tick();
    idle_inputs();
  endtask

  task automatic b_read(input int addr);
    b_en = 1'b1; b_addr = AW'(addr);
    tick();
    idle_inputs();
  endtask

  // Ticks until busy drops, bounded; returns the number of cycles busy stayed high.
  task automatic measure_sweep(output int n);
    n = 0;
    while (busy[0] === 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    idle_inputs();
    a_addr = '0; a_din = '0; b_addr = '0;
    #3;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({a_dout[d], b_dout[d]} !== 64'h0) begin
        errors++; $display("FAIL reset_dout[%0d]: got %h/%h expected 0/0", d, a_dout[d], b_dout[d]);
      end
      checks++;
      if ({a_valid[d], b_valid[d], busy[d]} !== 3'b001) begin
        errors++; $display("FAIL reset_flags[%0d]: got %b expected 001", d, {a_valid[d], b_valid[d], busy[d]});
      end
    end
    tick(); tick();
    #2 reset = 1'b0;
    measure_sweep(n);
    checks++;
    if (n !== DEPTH) begin
      errors++; $display("FAIL reset_sweep_len: got %0d expected %0d", n, DEPTH);
    end
  endtask

  task automatic test_write_read();
    a_write(5, 32'hDEADBEEF, 4'hF);
    checks++;
    if (a_dout[0] !== 32'h0 || a_valid[0] !== 1'b1) begin
      errors++; $display("FAIL t1_a_read_first: got %h v%b expected 00000000 v1", a_dout[0], a_valid[0]);
    end
    checks++;
    if (a_dout[1] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL t1_a_write_first: got %h expected deadbeef", a_dout[1]);
    end
    b_read(5);
    checks++;
    if (b_dout[0] !== 32'hDEADBEEF || b_valid[0] !== 1'b1) begin
      errors++; $display("FAIL t1_b_read: got %h v%b expected deadbeef v1", b_dout[0], b_valid[0]);
    end
    checks++;
    if (a_valid[0] !== 1'b0) begin
      errors++; $display("FAIL t1_a_valid_pulse: got %b expected 0", a_valid[0]);
    end
    tick();
    checks++;
    if (b_dout[0] !== 32'hDEADBEEF || b_valid[0] !== 1'b0) begin
      errors++; $display("FAIL t1_b_hold: got %h v%b expected deadbeef v0", b_dout[0], b_valid[0]);
    end
    checks++;
    if (b_dout[2] !== 32'hDEADBEEF || b_valid[2] !== 1'b1) begin
      errors++; $display("FAIL t1_b_lat2: got %h v%b expected deadbeef v1", b_dout[2], b_valid[2]);
    end
  endtask

  task automatic test_byte_enables();
    a_write(5, 32'h11223344, 4'b0101);
    checks++;
    if (a_dout[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL t2_a_read_first: got %h expected deadbeef", a_dout[0]);
    end
    checks++;
    if (a_dout[1] !== 32'hDE22BE44) begin
      errors++; $display("FAIL t2_a_write_first_merge: got %h expected de22be44", a_dout[1]);
    end
    b_read(5);
    checks++;
    if (b_dout[0] !== 32'hDE22BE44) begin
      errors++; $display("FAIL t2_b_merged: got %h expected de22be44", b_dout[0]);
    end
  endtask

  task automatic test_rdw_collision();
    a_write(7, 32'hAA, 4'hF);
    a_en = 1'b1; a_we = 4'hF; a_addr = 5'd7; a_din = 32'h55;
    b_en = 1'b1; b_addr = 5'd7;
    tick();
    idle_inputs();
    checks++;
    if (a_dout[0] !== 32'hAA) begin
      errors++; $display("FAIL t3_a_mode0: got %h expected 000000aa", a_dout[0]);
    end
    checks++;
    if (a_dout[1] !== 32'h55) begin
      errors++; $display("FAIL t3_a_mode1: got %h expected 00000055", a_dout[1]);
    end
    checks++;
    if (b_dout[0] !== 32'hAA || b_dout[1] !== 32'hAA) begin
      errors++; $display("FAIL t3_b_old: got %h/%h expected 000000aa/000000aa", b_dout[0], b_dout[1]);
    end
    b_read(7);
    checks++;
    if (b_dout[0] !== 32'h55) begin
      errors++; $display("FAIL t3_b_after: got %h expected 00000055", b_dout[0]);
    end
  endtask

  task automatic test_latency2();
    logic [4:0] exp_v;
    for (int i = 0; i < 3; i++) a_write(i, 32'hC0DE0000 + DW'(i), 4'hF);
    exp_v = 5'b01110;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin b_en = 1'b1; b_addr = AW'(k); end
      else b_en = 1'b0;
      tick();
      checks++;
      if (b_valid[2] !== exp_v[4-k]) begin
        errors++; $display("FAIL t4_valid_k%0d: got %b expected %b", k, b_valid[2], exp_v[4-k]);
      end
      if (k >= 1) begin
        checks++;
        if (b_dout[2] !== 32'hC0DE0000 + DW'((k > 3) ? 2 : k - 1)) begin
          errors++; $display("FAIL t4_data_k%0d: got %h expected %h", k, b_dout[2],
                             32'hC0DE0000 + DW'((k > 3) ? 2 : k - 1));
        end
      end
    end
    b_read(DEPTH);
    checks++;
    if (b_dout[0] !== 32'h0 || b_valid[0] !== 1'b1) begin
      errors++; $display("FAIL t4_oor_lat1: got %h v%b expected 00000000 v1", b_dout[0], b_valid[0]);
    end
    tick();
    checks++;
    if (b_dout[2] !== 32'h0 || b_valid[2] !== 1'b1) begin
      errors++; $display("FAIL t4_oor_lat2: got %h v%b expected 00000000 v1", b_dout[2], b_valid[2]);
    end
    a_write(DEPTH, 32'h12345678, 4'hF);
    checks++;
    if (a_dout[1] !== 32'h0 || a_valid[1] !== 1'b1) begin
      errors++; $display("FAIL t4_oor_a_read: got %h v%b expected 00000000 v1", a_dout[1], a_valid[1]);
    end
    b_read(0);
    checks++;
    if (b_dout[0] !== 32'hC0DE0000) begin
      errors++; $display("FAIL t4_oor_write_dropped: got %h expected c0de0000", b_dout[0]);
    end
  endtask

  task automatic test_clear();
    int n;
    for (int i = 0; i < DEPTH; i++) a_write(i, 32'hFFFFFFFF, 4'hF);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++; $display("FAIL t5_busy_rise: got %b expected 1", busy[0]);
    end
    n = 0;
    while (busy[0] === 1'b1 && n < 40) begin
      if (n == 4) begin a_en = 1'b1; a_we = 4'hF; a_addr = '0; a_din = 32'h77; end
      if (n == 8) clear_req = 1'b1;
      tick();
      n++;
      if (n == 5) begin
        checks++;
        if (a_valid[0] !== 1'b0 || a_valid[1] !== 1'b0) begin
          errors++; $display("FAIL t5_access_dropped: got %b/%b expected 0/0", a_valid[0], a_valid[1]);
        end
      end
      idle_inputs();
    end
    checks++;
    if (n !== DEPTH) begin
      errors++; $display("FAIL t5_busy_len: got %0d expected %0d", n, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      b_read(i);
      checks++;
      if (b_dout[0] !== 32'h0 || b_valid[0] !== 1'b1) begin
        errors++; $display("FAIL t5_cleared_%0d: got %h v%b expected 00000000 v1", i, b_dout[0], b_valid[0]);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    for (int i = 0; i < DEPTH; i++) a_write(i, 32'h5A5A0000 + DW'(i), 4'hF);
    a_en = 1'b1; a_we = 4'h0; a_addr = 5'd2;
    b_en = 1'b1; b_addr = 5'd3;
    tick();
    idle_inputs();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (6) tick();
    checks++;
    if (a_dout[0] !== 32'h5A5A0002 || b_dout[0] !== 32'h5A5A0003) begin
      errors++; $display("FAIL t6_hold_busy: got %h/%h expected 5a5a0002/5a5a0003", a_dout[0], b_dout[0]);
    end
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({a_dout[d], b_dout[d]} !== 64'h0 || {a_valid[d], b_valid[d], busy[d]} !== 3'b001) begin
        errors++; $display("FAIL t6_async_reset[%0d]: got %h/%h flags %b expected 0/0 flags 001",
                           d, a_dout[d], b_dout[d], {a_valid[d], b_valid[d], busy[d]});
      end
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    measure_sweep(n);
    checks++;
    if (n !== DEPTH) begin
      errors++; $display("FAIL t6_sweep_len: got %0d expected %0d", n, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      b_read(i);
      checks++;
      if (b_dout[0] !== 32'h0) begin
        errors++; $display("FAIL t6_cleared_%0d: got %h expected 00000000", i, b_dout[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enables();
    test_rdw_collision();
    test_latency2();
    test_clear();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
